pc_sequencer: RTL and testbench

- Controller for the 32-bit program counter register. It drives that register's next-address input and its wait_until_next_cycle_flag hold input.
- Selects the next PC (sequential, branch, jump, reset vector) and inserts stall cycles while instruction or data memory is not ready.
- Latches redirects across multi-cycle data accesses.
- Implements halt/resume and a wait-timeout watchdog. Sits between the branch/jump decode logic, the memory ready signals, and the PC register.

---
 rtl/pc_seq_pkg.sv | 6 +
 rtl/pc_sequencer_pc_next_mux.sv | 22 ++
 rtl/pc_sequencer.sv | 100 ++++++++++
 tb/tb_pc_sequencer.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared state encoding and constants for the PC sequencer
package pc_seq_pkg;
    typedef enum logic [2:0] {BOOT, RUN, FETCH_WAIT, MEM_WAIT, HALT} state_t;
    localparam int INSTR_BYTES = 4;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
endpackage

// File: rtl/pc_sequencer_pc_next_mux.sv
// pc_next_mux: jump/branch/sequential target select with alignment check
module pc_next_mux
    import pc_seq_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0] pc_cur,
    input  logic         branch_taken,
    input  logic [N-1:0] branch_target,
    input  logic         jump,
    input  logic [N-1:0] jump_target,
    output logic [N-1:0] seq_target,
    output logic         misaligned
);
    logic [N-1:0] redirect;
    // jump outranks branch; redirect targets are forced word-aligned
    always_comb begin
        redirect   = jump ? jump_target : branch_target;
        misaligned = (jump || branch_taken) && redirect[1:0] != 2'b00;
        seq_target = (jump || branch_taken) ? {redirect[N-1:2], 2'b00} : pc_cur + N'(INSTR_BYTES);
    end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC control with fetch/data stalls, halt and wait watchdog
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int          N            = 32,
    parameter logic [N-1:0] RESET_VECTOR = N'(DEFAULT_RESET_VECTOR),
    parameter int          TIMEOUT      = 256
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] pc_cur,
    input  logic         branch_taken,
    input  logic [N-1:0] branch_target,
    input  logic         jump,
    input  logic [N-1:0] jump_target,
    input  logic         mem_access,
    input  logic         imem_ready,
    input  logic         dmem_ready,
    input  logic         halt_req,
    input  logic         resume,
    output logic [N-1:0] pc_next,
    output logic         wait_until_next_cycle_flag,
    output logic         instr_commit,
    output logic         halted,
    output logic         misalign_err,
    output logic         timeout_err,
    output logic [15:0]  stall_count
);
    state_t       state;
    logic [N-1:0] target_q;
    logic [31:0]  wait_cnt;
    logic [N-1:0] seq_target;
    logic         misaligned;
    logic         waiting;
    logic         ready;
    logic         trip;
    logic         run_go;
    logic         run_commit;
    logic         mem_commit;

    pc_next_mux #(.N(N)) u_mux (
        .pc_cur        (pc_cur),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .seq_target    (seq_target),
        .misaligned    (misaligned)
    );

    // commit/hold decode and next-PC select, sampled by the PC register at the same edge
    always_comb begin
        waiting      = state == FETCH_WAIT || state == MEM_WAIT;
        ready        = state == MEM_WAIT ? dmem_ready : imem_ready;
        trip         = waiting && !ready && TIMEOUT != 0 && wait_cnt == 32'(TIMEOUT - 1);
        run_go       = state == RUN && !halt_req && imem_ready;
        run_commit   = run_go && !(mem_access && !dmem_ready);
        mem_commit   = state == MEM_WAIT && dmem_ready;
        instr_commit = run_commit || mem_commit;
        wait_until_next_cycle_flag = state != BOOT && !instr_commit;
        pc_next      = state == BOOT ? RESET_VECTOR : run_commit ? seq_target : mem_commit ? target_q : pc_cur;
        halted       = state == HALT;
    end

    // state machine, latched redirect, wait watchdog, stall counter and sticky errors
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= BOOT;
            target_q     <= '0;
            wait_cnt     <= '0;
            stall_count  <= '0;
            misalign_err <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            wait_cnt <= waiting ? wait_cnt + 32'd1 : 32'd0;
            if (wait_until_next_cycle_flag && state != HALT && stall_count != 16'hFFFF)
                stall_count <= stall_count + 16'd1;
            if (run_go && misaligned)
                misalign_err <= 1'b1;
            if (trip)
                timeout_err <= 1'b1;
            case (state)
                BOOT: state <= RUN;
                RUN: begin
                    if (halt_req)
                        state <= HALT;
                    else if (!imem_ready)
                        state <= FETCH_WAIT;
                    else if (mem_access && !dmem_ready) begin
                        target_q <= seq_target;
                        state    <= MEM_WAIT;
                    end
                end
                FETCH_WAIT, MEM_WAIT: state <= ready ? RUN : trip ? HALT : state;
                HALT: state <= resume ? RUN : HALT;
                default: state <= BOOT;
            endcase
        end
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed checks of the PC sequencer against a behavioural PC register
module tb_pc_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc_cur, branch_target, jump_target, pc_next;
    logic        branch_taken, jump, mem_access, imem_ready, dmem_ready, halt_req, resume;
    logic        flag, commit, halted, misalign_err, timeout_err;
    logic [15:0] stall_count;
    logic        imem2;
    logic [31:0] pc_next2;
    logic        flag2, commit2, halted2, mis2, to2;
    logic [15:0] stall2;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    always @(posedge clk or posedge reset)
        if (reset) pc_cur <= 32'hFFFF_FFF0;
        else if (!flag) pc_cur <= pc_next;

    pc_sequencer #(.TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .pc_cur(pc_cur),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target), .mem_access(mem_access),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .halt_req(halt_req), .resume(resume), .pc_next(pc_next),
        .wait_until_next_cycle_flag(flag), .instr_commit(commit),
        .halted(halted), .misalign_err(misalign_err),
        .timeout_err(timeout_err), .stall_count(stall_count)
    );

    pc_sequencer #(.TIMEOUT(0)) dut2 (
        .clk(clk), .reset(reset), .pc_cur(32'h0),
        .branch_taken(1'b0), .branch_target(32'h0),
        .jump(1'b0), .jump_target(32'h0), .mem_access(1'b0),
        .imem_ready(imem2), .dmem_ready(1'b0),
        .halt_req(1'b0), .resume(1'b0), .pc_next(pc_next2),
        .wait_until_next_cycle_flag(flag2), .instr_commit(commit2),
        .halted(halted2), .misalign_err(mis2),
        .timeout_err(to2), .stall_count(stall2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        {branch_taken, jump, mem_access, dmem_ready, halt_req, resume} = '0;
        imem_ready = 1'b1; imem2 = 1'b1;
        branch_target = '0; jump_target = '0;
        #1;
        chk("rst_pc_next", pc_next, 32'h0);
        chk("rst_flag", 32'(flag), 32'd0);
        chk("rst_commit", 32'(commit), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_misalign", 32'(misalign_err), 32'd0);
        chk("rst_timeout", 32'(timeout_err), 32'd0);
        chk("rst_stall", 32'(stall_count), 32'd0);
        @(negedge clk); reset = 1'b0; #1;
        chk("boot_pc_next", pc_next, 32'h0);
        chk("boot_flag", 32'(flag), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            chk("seq_pc_cur", pc_cur, 32'(4 * i));
            chk("seq_commit", 32'(commit), 32'd1);
            chk("seq_pc_next", pc_next, 32'(4 * i + 4));
        end
        @(negedge clk); jump = 1'b1; jump_target = 32'h100; branch_taken = 1'b1; branch_target = 32'h200; #1;
        chk("prio_pc_cur", pc_cur, 32'h10);
        chk("prio_pc_next", pc_next, 32'h100);
        chk("prio_commit", 32'(commit), 32'd1);
        @(negedge clk); jump_target = 32'h20; branch_taken = 1'b0; #1;
        chk("jmp_pc_cur", pc_cur, 32'h100);
        chk("jmp_pc_next", pc_next, 32'h20);
        @(negedge clk); jump = 1'b0; mem_access = 1'b1; branch_taken = 1'b1; branch_target = 32'h40; #1;
        chk("ld_pc_cur", pc_cur, 32'h20);
        chk("ld_flag0", 32'(flag), 32'd1);
        chk("ld_hold0", pc_next, 32'h20);
        chk("ld_commit0", 32'(commit), 32'd0);
        @(negedge clk); branch_target = 32'h80; #1;
        chk("ld_flag1", 32'(flag), 32'd1);
        chk("ld_hold1", pc_next, 32'h20);
        @(negedge clk); #1;
        chk("ld_flag2", 32'(flag), 32'd1);
        chk("ld_hold2", pc_next, 32'h20);
        @(negedge clk); dmem_ready = 1'b1; #1;
        chk("ld_done_pc_next", pc_next, 32'h40);
        chk("ld_done_flag", 32'(flag), 32'd0);
        chk("ld_done_commit", 32'(commit), 32'd1);
        chk("ld_stall", 32'(stall_count), 32'd3);
        @(negedge clk); mem_access = 1'b0; branch_taken = 1'b0; imem_ready = 1'b0; #1;
        chk("if_pc_cur", pc_cur, 32'h40);
        chk("if_flag0", 32'(flag), 32'd1);
        chk("if_commit0", 32'(commit), 32'd0);
        @(negedge clk); #1;
        chk("if_flag1", 32'(flag), 32'd1);
        chk("if_hold1", pc_next, 32'h40);
        @(negedge clk); imem_ready = 1'b1; #1;
        chk("if_exit_flag", 32'(flag), 32'd1);
        chk("if_exit_commit", 32'(commit), 32'd0);
        @(negedge clk); #1;
        chk("if_resume_pc_cur", pc_cur, 32'h40);
        chk("if_resume_commit", 32'(commit), 32'd1);
        chk("if_resume_pc_next", pc_next, 32'h44);
        chk("if_stall", 32'(stall_count), 32'd6);
        @(negedge clk); mem_access = 1'b1; dmem_ready = 1'b0; #1;
        chk("to_enter_flag", 32'(flag), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            chk("to_wait_halted", 32'(halted), 32'd0);
            chk("to_wait_err", 32'(timeout_err), 32'd0);
            chk("to_wait_flag", 32'(flag), 32'd1);
        end
        @(negedge clk); mem_access = 1'b0; #1;
        chk("to_halted", 32'(halted), 32'd1);
        chk("to_err", 32'(timeout_err), 32'd1);
        chk("to_flag", 32'(flag), 32'd1);
        chk("to_stall", 32'(stall_count), 32'd11);
        @(negedge clk); resume = 1'b1; #1;
        chk("halt_still", 32'(halted), 32'd1);
        chk("halt_no_stall", 32'(stall_count), 32'd11);
        chk("halt_commit", 32'(commit), 32'd0);
        @(negedge clk); resume = 1'b0; #1;
        chk("res_halted", 32'(halted), 32'd0);
        chk("res_commit", 32'(commit), 32'd1);
        chk("res_pc_cur", pc_cur, 32'h44);
        chk("res_pc_next", pc_next, 32'h48);
        chk("res_err_sticky", 32'(timeout_err), 32'd1);
        @(negedge clk); mem_access = 1'b1; #1;
        chk("mw_enter_flag", 32'(flag), 32'd1);
        @(negedge clk); #1;
        chk("mw_flag", 32'(flag), 32'd1);
        reset = 1'b1; #1;
        chk("arst_pc_next", pc_next, 32'h0);
        chk("arst_flag", 32'(flag), 32'd0);
        chk("arst_timeout", 32'(timeout_err), 32'd0);
        chk("arst_stall", 32'(stall_count), 32'd0);
        chk("arst_halted", 32'(halted), 32'd0);
        @(negedge clk); reset = 1'b0; mem_access = 1'b0; #1;
        chk("reboot_pc_next", pc_next, 32'h0);
        chk("reboot_pc_cur", pc_cur, 32'hFFFF_FFF0);
        @(negedge clk); branch_taken = 1'b1; branch_target = 32'h102; #1;
        chk("mis_pc_cur", pc_cur, 32'h0);
        chk("mis_before", 32'(misalign_err), 32'd0);
        chk("mis_pc_next", pc_next, 32'h100);
        chk("mis_commit", 32'(commit), 32'd1);
        @(negedge clk); branch_taken = 1'b0; jump = 1'b1; jump_target = 32'hFFFF_FFFC; #1;
        chk("mis_set", 32'(misalign_err), 32'd1);
        chk("mis_pc_cur2", pc_cur, 32'h100);
        @(negedge clk); jump = 1'b0; #1;
        chk("wrap_pc_cur", pc_cur, 32'hFFFF_FFFC);
        chk("wrap_pc_next", pc_next, 32'h0);
        chk("mis_sticky", 32'(misalign_err), 32'd1);
        @(negedge clk); halt_req = 1'b1; #1;
        chk("hr_pc_cur", pc_cur, 32'h0);
        chk("hr_flag", 32'(flag), 32'd1);
        chk("hr_commit", 32'(commit), 32'd0);
        @(negedge clk); resume = 1'b1; #1;
        chk("hr_halted", 32'(halted), 32'd1);
        @(negedge clk); halt_req = 1'b0; resume = 1'b0; #1;
        chk("hr_resume_halted", 32'(halted), 32'd0);
        chk("hr_resume_commit", 32'(commit), 32'd1);
        chk("hr_resume_pc_cur", pc_cur, 32'h0);
        chk("hr_mis_sticky", 32'(misalign_err), 32'd1);
        @(negedge clk); imem2 = 1'b0;
        repeat (100) @(negedge clk);
        #1;
        chk("sat_stall100", 32'(stall2), 32'd100);
        chk("sat_flag", 32'(flag2), 32'd1);
        chk("sat_hold", pc_next2, 32'h0);
        chk("sat_commit", 32'(commit2), 32'd0);
        repeat (65500) @(negedge clk);
        #1;
        chk("sat_stall_max", 32'(stall2), 32'h0000_FFFF);
        chk("sat_no_timeout", 32'(to2), 32'd0);
        chk("sat_not_halted", 32'(halted2), 32'd0);
        chk("sat_no_misalign", 32'(mis2), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
